// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations; the slave (the subtractor) reports results.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             done;

    modport master (
        output start, A, B,
        input  ready, D, Bo, done
    );

    modport slave (
        input  start, A, B,
        output ready, D, Bo, done
    );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: D = A - B computed LSB first over WIDTH cycles
// through two chained half-subtractor stages and a registered borrow.
module serial_subtractor_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                    clk,
    input logic                    rst,
    serial_subtractor_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             done_q;

    logic d1;
    logic b1;
    logic d;
    logic b2;
    logic bout;
    logic last_bit;

    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign bus.ready = (state == IDLE) && !rst;
    assign bus.D     = d_q;
    assign bus.Bo    = bo_q;
    assign bus.done  = done_q;

    always_comb begin
        d1         = a_sh[0] ^ b_sh[0];
        b1         = ~a_sh[0] & b_sh[0];
        d          = d1 ^ borrow;
        b2         = ~d1 & borrow;
        bout       = b1 | b2;
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The counter wraps to 0 on the last bit so it never reads WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bo_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.A;
                        b_sh   <= bus.B;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    r_sh   <= {d, r_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= bout;
                    cnt    <= last_bit ? '0 : cnt + CNT_W'(1);
                    if (last_bit) begin
                        d_q    <= {d, r_sh[WIDTH-1:1]};
                        bo_q   <= bout;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and streaming checks of the bit-serial subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl_if #(.WIDTH(8))  bus8();
    serial_subtractor_ctrl_if #(.WIDTH(16)) bus16();

    serial_subtractor_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Presents one start pulse on the 8-bit DUT; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        checkOutput("ready_before_start", {31'b0, bus8.ready}, 32'd1);
        bus8.A     = a;
        bus8.B     = b;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] expD, input logic expBo);
        int k;
        applyStimulus(a, b);
        k = 0;
        while (k < 40 && !bus8.done) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_latency", k, 8);
        checkOutput("result_D", {24'b0, bus8.D}, {24'b0, expD});
        checkOutput("result_Bo", {31'b0, bus8.Bo}, {31'b0, expBo});
        @(negedge clk);
        checkOutput("ready_after_done", {31'b0, bus8.ready}, 32'd1);
        checkOutput("done_one_cycle", {31'b0, bus8.done}, 32'd0);
    endtask

    // Start tied high on one DUT; every accepted pair is queued and matched to its done pulse.
    task automatic streamCheck(input int which, input int n);
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] mask, a, b, ea, eb, dObs;
        int launched, received, cyc, lastDone, w;
        logic rdy, dn, boObs;
        launched = 0; received = 0; cyc = 0; lastDone = -1;
        w    = (which != 0) ? 16 : 8;
        mask = (32'd1 << w) - 32'd1;
        while (received < n && cyc < n * (w + 2) + 200) begin
            @(negedge clk);
            cyc++;
            rdy   = (which != 0) ? bus16.ready : bus8.ready;
            dn    = (which != 0) ? bus16.done  : bus8.done;
            dObs  = (which != 0) ? {16'b0, bus16.D} : {24'b0, bus8.D};
            boObs = (which != 0) ? bus16.Bo : bus8.Bo;
            if (dn) begin
                if (qa.size() == 0) begin
                    checkOutput("stream_unexpected_done", 32'd1, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    checkOutput("stream_D", dObs, (ea - eb) & mask);
                    checkOutput("stream_Bo", {31'b0, boObs}, {31'b0, (ea < eb)});
                    if (lastDone >= 0) checkOutput("stream_spacing", cyc - lastDone, w + 2);
                end
                lastDone = cyc;
                received++;
            end
            if (rdy) begin
                if (launched < n) begin
                    a = $urandom & mask;
                    b = $urandom & mask;
                    if (which != 0) begin
                        bus16.A = a[15:0]; bus16.B = b[15:0]; bus16.start = 1'b1;
                    end else begin
                        bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.start = 1'b1;
                    end
                    qa.push_back(a);
                    qb.push_back(b);
                    launched++;
                end else begin
                    bus8.start  = 1'b0;
                    bus16.start = 1'b0;
                end
            end
        end
        bus8.start  = 1'b0;
        bus16.start = 1'b0;
        checkOutput("stream_count", received, n);
    endtask

    initial begin
        int k, doneSeen;
        bus8.start = 1'b0;  bus8.A = '0;  bus8.B = '0;
        bus16.start = 1'b0; bus16.A = '0; bus16.B = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'b0, bus8.ready}, 32'd0);
        checkOutput("reset_D", {24'b0, bus8.D}, 32'd0);
        checkOutput("reset_Bo", {31'b0, bus8.Bo}, 32'd0);
        checkOutput("reset_done", {31'b0, bus8.done}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'b0, bus8.ready}, 32'd1);

        runOp(8'd100, 8'd37, 8'd63, 1'b0);
        runOp(8'd37, 8'd100, 8'hC1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold_D", {24'b0, bus8.D}, 32'hC1);
            checkOutput("hold_Bo", {31'b0, bus8.Bo}, 32'd1);
        end
        runOp(8'd0, 8'd255, 8'd1, 1'b1);
        runOp(8'd255, 8'd255, 8'd0, 1'b0);

        // Extra start pulses while running must not disturb the first operands.
        applyStimulus(8'd200, 8'd13);
        doneSeen = 0;
        for (k = 1; k <= 14; k++) begin
            if (k == 3 || k == 5) begin
                bus8.A = 8'd1; bus8.B = 8'd2; bus8.start = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            if (bus8.done) begin
                doneSeen++;
                checkOutput("ignore_D", {24'b0, bus8.D}, 32'd187);
                checkOutput("ignore_Bo", {31'b0, bus8.Bo}, 32'd0);
            end
        end
        bus8.start = 1'b0;
        checkOutput("ignore_done_count", doneSeen, 1);

        applyStimulus(8'd50, 8'd7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_D", {24'b0, bus8.D}, 32'd0);
        checkOutput("abort_Bo", {31'b0, bus8.Bo}, 32'd0);
        checkOutput("abort_done", {31'b0, bus8.done}, 32'd0);
        checkOutput("abort_ready", {31'b0, bus8.ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready_release", {31'b0, bus8.ready}, 32'd1);
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus8.done) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 0);

        streamCheck(0, 1000);
        streamCheck(1, 1000);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial unsigned subtractor controller. It computes D = A - B over WIDTH cycles, LSB first. Each cycle it drives one shared 1-bit datapath built from two chained half-subtractor stages and a registered borrow. The block owns operand capture, bit sequencing, borrow storage, result assembly and the start/ready/done handshake. It is the area-minimal alternative to a WIDTH-wide ripple subtractor in the arithmetic section.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when ready=1.
A  input  WIDTH  minuend, captured on accepted start.
B  input  WIDTH  subtrahend, captured on accepted start.
ready  output  1  high only in IDLE and rst=0.
D  output  WIDTH  registered difference, (A-B) mod 2^WIDTH.
Bo  output  1  registered final borrow; 1 iff A<B unsigned.
done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, D=0, Bo=0, done=0, internal shift regs/borrow/counter=0.
  - ready=0 while rst=1.
  - Reset mid-RUN or in DONE aborts the operation; no done pulse; D/Bo cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge (accept edge, edge 0) loads a_sh<=A, b_sh<=B, borrow<=0, cnt<=0, state<=RUN.
  - A/B are don't-care when start=0.
- RUN:
  - ready=0; start is ignored and A/B are not sampled.
  - Per cycle, on a=a_sh[0], b=b_sh[0], bin=borrow:
    - stage 1: d1=a^b, b1=~a&b.
    - stage 2: d=d1^bin, b2=~d1&bin.
    - bout=b1|b2.
  - Each edge: r_sh<={d, r_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; borrow<=bout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (edge WIDTH after accept):
    - D<=final r_sh including this bit;
    - Bo<=bout;
    - state<=DONE.
- DONE:
  - done=1 for exactly this one cycle; ready=0.
  - Next edge: state<=IDLE, done<=0.
- Latency: accept edge = edge 0, done high during the cycle following edge WIDTH; throughput is one operation per WIDTH+2 cycles.
- D/Bo:
  - change only at the completion edge or on reset;
  - hold their value through IDLE until the next completion, including while a new operation runs.
- Boundaries:
  - A=B gives D=0, Bo=0.
  - A=0, B=2^WIDTH-1 gives D=1, Bo=1.
  - Borrow does not leak between operations (cleared on accept).
  - cnt never exceeds WIDTH-1 in RUN.
- start held high continuously: operations are accepted back-to-back, one each time IDLE is re-entered (every WIDTH+2 cycles).
- No X propagation: all state registers are reset; outputs are defined every cycle after the first reset edge.

Test Plan:
- WIDTH=8, reset then A=100, B=37, start pulse -> done=1 exactly 8 cycles after the cycle following the accept edge; D=63, Bo=0; ready returns 1 the next cycle.
- A=37, B=100 -> D=8'd193 (0xC1), Bo=1; D/Bo hold 0xC1/1 through 20 idle cycles.
- A=0, B=255 -> D=1, Bo=1; then A=255, B=255 -> D=0, Bo=0 (proves borrow is cleared between operations).
- start pulsed at cycles 3 and 5 of RUN with different A/B -> ignored; result matches the first operands; exactly one done pulse.
- rst asserted at RUN cycle 4 -> next cycle D=0, Bo=0, done=0, ready=0 while rst is high; ready=1 after rst drops; no done pulse.
- start tied high, 1000 random A/B pairs (WIDTH=8 and WIDTH=16) -> every done pulse has D==(A-B) mod 2^WIDTH and Bo==(A<B); done spacing exactly WIDTH+2 cycles.
